// File: rtl/generation_sequencer_pkg.sv
// Shared constants, board types and state encodings for the generation sequencer.
package generation_sequencer_pkg;

    localparam int unsigned ROWS  = 16;
    localparam int unsigned COLS  = 16;
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned ROW_W = 4;

    // Flat board as seen by the algorithm stage: bit i*COLS+j = row i, column j.
    typedef logic [CELLS-1:0] environment_t;
    // Same bits viewed as rows; packing matches environment_t exactly.
    typedef logic [ROWS-1:0][COLS-1:0] board_t;
    typedef logic [COLS-1:0] row_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StLoad = 2'd2
    } state_t;

    // True when a row index addresses a real board row.
    function automatic logic row_in_range(input logic [ROW_W-1:0] r);
        return (32'(r) < ROWS);
    endfunction

endpackage

// File: rtl/generation_sequencer_gen_timer.sv
// Generation prescaler: counts 0..GEN_DIV-1 while enabled, ticks on the terminal count.
module generation_sequencer_gen_timer #(
    parameter int unsigned GEN_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic [31:0] count;
    logic        terminal;

    assign terminal = (count == 32'(GEN_DIV - 1));
    assign tick     = enable & terminal;

    // Divider count; clear wins over enable, wraps to zero on the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + 32'd1;
        end
    end

endmodule

// File: rtl/generation_sequencer.sv
// Game of Life board owner: seed loading, run/pause/step sequencing and display read port.
module generation_sequencer
    import generation_sequencer_pkg::*;
#(
    parameter int unsigned GEN_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [ROW_W-1:0] seed_row,
    input  logic [COLS-1:0]  seed_data,
    input  logic             seed_last,
    input  logic             load_req,
    input  logic             run,
    input  logic             step,
    output logic [CELLS-1:0] cur_env,
    input  logic [CELLS-1:0] next_env,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data,
    output logic [15:0]      gen_count,
    output logic             stable,
    output logic             busy_load
);

    state_t state;
    board_t board;
    logic   timer_en;
    logic   gen_tick;

    // The divider starts counting on the edge that first sees run, so the first
    // commit lands GEN_DIV cycles after run is raised.
    assign timer_en = run & ~load_req & (state != StLoad);

    generation_sequencer_gen_timer #(
        .GEN_DIV (GEN_DIV)
    ) u_gen_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (~timer_en),
        .enable (timer_en),
        .tick   (gen_tick)
    );

    assign cur_env = board;
    assign stable  = (next_env == cur_env);

    // Sequencing FSM together with the board and generation counter it updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            board      <= '0;
            gen_count  <= '0;
            seed_ready <= 1'b0;
            busy_load  <= 1'b0;
        end else if (load_req) begin
            // Load request outranks everything and restarts the load from an empty board.
            state      <= StLoad;
            board      <= '0;
            gen_count  <= '0;
            seed_ready <= 1'b1;
            busy_load  <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (run) begin
                        state <= StRun;
                    end else if (step) begin
                        board     <= next_env;
                        gen_count <= gen_count + 16'd1;
                    end
                end
                StRun: begin
                    if (!run) begin
                        state <= StIdle;
                    end else if (gen_tick) begin
                        board     <= next_env;
                        gen_count <= gen_count + 16'd1;
                    end
                end
                StLoad: begin
                    if (seed_valid && seed_ready) begin
                        if (row_in_range(seed_row)) begin
                            board[seed_row] <= seed_data;
                        end
                        if (seed_last) begin
                            state      <= StIdle;
                            seed_ready <= 1'b0;
                            busy_load  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= StIdle;
                    seed_ready <= 1'b0;
                    busy_load  <= 1'b0;
                end
            endcase
        end
    end

    // Registered display read; sees the board as it was before any same-edge commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= row_in_range(rd_row) ? board[rd_row] : '0;
        end
    end

endmodule

// File: tb/tb_generation_sequencer.sv
// Bench for generation_sequencer with a behavioural Life algorithm stage downstream.
module tb_generation_sequencer;
    import generation_sequencer_pkg::*;

    localparam int unsigned DIV = 4;

    logic             clk;
    logic             rst;
    logic             seed_valid;
    logic             seed_ready;
    logic [ROW_W-1:0] seed_row;
    logic [COLS-1:0]  seed_data;
    logic             seed_last;
    logic             load_req;
    logic             run;
    logic             step;
    logic [CELLS-1:0] cur_env;
    logic [CELLS-1:0] next_env;
    logic [ROW_W-1:0] rd_row;
    logic [COLS-1:0]  rd_data;
    logic [15:0]      gen_count;
    logic             stable;
    logic             busy_load;

    int n_total = 0;
    int n_bad   = 0;

    row_t   rd_q[$];
    logic   rd_en;
    board_t exp_board;
    logic [15:0] exp_gen;

    generation_sequencer #(
        .GEN_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_row   (seed_row),
        .seed_data  (seed_data),
        .seed_last  (seed_last),
        .load_req   (load_req),
        .run        (run),
        .step       (step),
        .cur_env    (cur_env),
        .next_env   (next_env),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .gen_count  (gen_count),
        .stable     (stable),
        .busy_load  (busy_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toroidal Game of Life rule: birth on 3, survival on 2 or 3.
    function automatic board_t life_next(input board_t b);
        board_t n;
        int cnt;
        int rr;
        int cc;
        n = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = (r + dr + int'(ROWS)) % int'(ROWS);
                            cc = (c + dc + int'(COLS)) % int'(COLS);
                            cnt += int'(b[rr][cc]);
                        end
                    end
                end
                n[r][c] = (cnt == 3) || (b[r][c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Algorithm stage driven by the DUT's current board.
    assign next_env = life_next(cur_env);

    task automatic check_val(input string tag, input logic [CELLS-1:0] obs,
                             input logic [CELLS-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read-port scoreboard: a read issued before an edge is compared just after it.
    initial begin
        logic v;
        forever begin
            @(posedge clk);
            v = rd_en;
            #1;
            if (v && rd_q.size() > 0) begin
                check_val("rd_data", rd_data, rd_q.pop_front());
            end
        end
    end

    // Issue a read of every row, expecting the bench's model board.
    task automatic read_all();
        for (int i = 0; i < int'(ROWS); i++) begin
            rd_en  = 1'b1;
            rd_row = ROW_W'(i);
            rd_q.push_back(exp_board[i]);
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_board"}, cur_env, exp_board);
        check_val({tag, "_gen"}, gen_count, exp_gen);
    endtask

    // Full LOAD sequence; optional junk beat on row 5 checks last-write-wins.
    task automatic load_board(input board_t b, input bit dup);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check_val("ld_ready", seed_ready, 1);
        check_val("ld_busy", busy_load, 1);
        check_val("ld_clear", cur_env, 0);
        check_val("ld_gen", gen_count, 0);
        if (dup) begin
            seed_valid = 1'b1;
            seed_row   = ROW_W'(5);
            seed_data  = '1;
            seed_last  = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < int'(ROWS); i++) begin
            seed_valid = 1'b1;
            seed_row   = ROW_W'(i);
            seed_data  = b[i];
            seed_last  = (i == int'(ROWS) - 1);
            @(negedge clk);
        end
        seed_valid = 1'b0;
        seed_last  = 1'b0;
        check_val("ld_done_ready", seed_ready, 0);
        check_val("ld_done_busy", busy_load, 0);
        check_val("ld_board", cur_env, b);
        exp_board = b;
        exp_gen   = '0;
    endtask

    initial begin
        board_t blinker;
        board_t vert;
        board_t glider;
        board_t block;
        board_t empty;

        blinker    = '0;
        blinker[5] = 16'h01C0;
        vert       = '0;
        vert[4]    = 16'h0080;
        vert[5]    = 16'h0080;
        vert[6]    = 16'h0080;
        glider     = '0;
        glider[0]  = 16'h0002;
        glider[1]  = 16'h0004;
        glider[2]  = 16'h0007;
        block      = '0;
        block[3]   = 16'h0018;
        block[4]   = 16'h0018;
        empty      = '0;

        rst = 1'b1; seed_valid = 1'b0; seed_row = '0; seed_data = '0; seed_last = 1'b0;
        load_req = 1'b0; run = 1'b0; step = 1'b0; rd_row = '0; rd_en = 1'b0;
        exp_board = '0; exp_gen = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Reset / idle state.
        check_state("rst");
        check_val("rst_ready", seed_ready, 0);
        check_val("rst_busy", busy_load, 0);
        check_val("rst_stable", stable, 1);
        read_all();

        // Single step on a blinker, with a same-edge read of the committed row.
        load_board(blinker, 1'b1);
        check_val("blink_stable", stable, 0);
        step  = 1'b1;
        rd_en = 1'b1;
        rd_row = ROW_W'(5);
        rd_q.push_back(16'h01C0);
        @(negedge clk);
        step  = 1'b0;
        rd_en = 1'b0;
        exp_board = life_next(exp_board);
        exp_gen   = 16'd1;
        check_state("step");
        check_val("step_vert", cur_env, vert);
        read_all();

        // Free-run 8 cycles: commits on the 4th and 8th edge; step ignored while running.
        load_board(blinker, 1'b0);
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            step = (k == 1);
            if (k == 4) begin
                check_val("run4_board", cur_env, vert);
                check_val("run4_gen", gen_count, 1);
            end
        end
        run = 1'b0;
        check_val("run8_board", cur_env, blinker);
        check_val("run8_gen", gen_count, 2);
        repeat (6) @(negedge clk);
        exp_board = blinker;
        exp_gen   = 16'd2;
        check_state("paused");

        // Glider wraps the torus in 64 generations.
        load_board(glider, 1'b0);
        run = 1'b1;
        for (int k = 1; k <= int'(DIV) * 64; k++) begin
            @(negedge clk);
            if (k == int'(DIV) * 32) begin
                for (int g = 0; g < 32; g++) exp_board = life_next(exp_board);
                exp_gen = 16'd32;
                check_state("glider32");
            end
        end
        run = 1'b0;
        check_val("glider_home", cur_env, glider);
        check_val("glider_gen", gen_count, 64);
        @(negedge clk);

        // Still life.
        load_board(block, 1'b0);
        check_val("block_stable", stable, 1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        exp_gen = 16'd1;
        check_state("block_step");

        // load_req mid-RUN: LOAD on the next cycle, board cleared; run ignored in LOAD.
        load_board(blinker, 1'b0);
        run = 1'b1;
        repeat (6) @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check_val("midrun_ready", seed_ready, 1);
        check_val("midrun_busy", busy_load, 1);
        check_val("midrun_board", cur_env, 0);
        check_val("midrun_gen", gen_count, 0);
        exp_board = '0;
        // Row 17 truncates to the 4-bit index 1; board is empty so it reads 0.
        rd_en  = 1'b1;
        rd_row = ROW_W'(17);
        rd_q.push_back('0);
        @(negedge clk);
        rd_en = 1'b0;
        repeat (4) @(negedge clk);
        check_val("load_run_busy", busy_load, 1);
        check_val("load_run_gen", gen_count, 0);
        run        = 1'b0;
        seed_valid = 1'b1;
        seed_row   = ROW_W'(0);
        seed_data  = 16'h0001;
        seed_last  = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        seed_last  = 1'b0;
        check_val("exit_busy", busy_load, 0);
        check_val("exit_board", cur_env, 1);

        // Asynchronous reset in the middle of LOAD.
        load_req = 1'b1;
        @(negedge clk);
        load_req   = 1'b0;
        seed_valid = 1'b1;
        seed_row   = ROW_W'(2);
        seed_data  = 16'hAAAA;
        @(negedge clk);
        seed_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", busy_load, 0);
        check_val("arst_ready", seed_ready, 0);
        check_val("arst_board", cur_env, 0);
        check_val("arst_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Step held high commits every cycle; counter wraps 0xFFFF -> 0 on an empty board.
        check_val("empty_stable", stable, 1);
        step = 1'b1;
        repeat (65535) @(negedge clk);
        check_val("wrap_ffff", gen_count, 16'hFFFF);
        @(negedge clk);
        step = 1'b0;
        check_val("wrap_zero", gen_count, 0);
        check_val("wrap_board", cur_env, empty);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
